// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: shares one fixed-latency, fully pipelined FP unit between two
// requesters. Grants at most one operand pair per cycle, registers it onto the
// unit inputs, and returns each result to its issuer through a tag pipeline.
// Optional feature: define FP_ARB_ROUND_ROBIN_EN for round-robin contention;
// otherwise requester 0 has fixed priority.
module fp_unit_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             unit_valid,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    output logic             sel,
    input  logic [WIDTH-1:0] unit_result,
    output logic             resp0_valid,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp1_result
);

    logic               last_grant;
    logic               grant0;
    logic               grant1;
    logic               transfer;
    logic [LATENCY-1:0] tag_valid;
    logic [LATENCY-1:0] tag_id;
    logic               tag_out_valid;
    logic               tag_out_id;

    // Combinational grant; nothing is granted while reset is asserted
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
`ifdef FP_ARB_ROUND_ROBIN_EN
                grant0 = last_grant;
                grant1 = ~last_grant;
`else
                grant0 = 1'b1;
`endif
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign transfer   = grant0 | grant1;

    // Issue register: capture granted operands, hold them when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_valid <= 1'b0;
            unit_a     <= '0;
            unit_b     <= '0;
            sel        <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            unit_valid <= transfer;
            if (transfer) begin
                unit_a     <= grant1 ? req1_a : req0_a;
                unit_b     <= grant1 ? req1_b : req0_b;
                sel        <= grant1;
                last_grant <= grant1;
            end
        end
    end

    // Tag pipeline mirrors the unit latency so the owner is known on result return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid[0] <= unit_valid;
            tag_id[0]    <= sel;
            for (int i = 1; i < int'(LATENCY); i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign tag_out_valid = tag_valid[LATENCY-1];
    assign tag_out_id    = tag_id[LATENCY-1];

    // Response steering: one-cycle pulse to the issuer, other result holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp0_valid  <= 1'b0;
            resp1_valid  <= 1'b0;
            resp0_result <= '0;
            resp1_result <= '0;
        end else begin
            resp0_valid <= tag_out_valid & ~tag_out_id;
            resp1_valid <= tag_out_valid & tag_out_id;
            if (tag_out_valid && !tag_out_id) begin
                resp0_result <= unit_result;
            end
            if (tag_out_valid && tag_out_id) begin
                resp1_result <= unit_result;
            end
        end
    end

endmodule
